oct_stopwatch: RTL

//   Multi-digit octal up/down stopwatch. Generates one 3-bit octal digit per display

---
 rtl/oct_pkg.sv | 22 ++
 rtl/oct_digit_cnt.sv | 31 +++
 rtl/oct_stopwatch.sv | 97 +++++++++
 3 files changed

// File: rtl/oct_pkg.sv
// Shared definitions for the octal stopwatch: digit width, run/stop encoding
// and a constant-evaluable ceil(log2) for sizing the prescaler.
package oct_pkg;

  localparam int OCT_W = 3;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Minimum result is 1 so a counter never ends up zero bits wide.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/oct_digit_cnt.sv
// One octal digit of the stopwatch chain. cy_o flags that this digit would roll
// over (7 going up, 0 going down), so the next digit may step with it.
module oct_digit_cnt
  import oct_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             clr_i,
  output logic [OCT_W-1:0] digit_o,
  output logic             cy_o
);

  logic [OCT_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr_i)     digit_d = '0;
    else if (en_i) digit_d = up_i ? digit_q + 3'd1 : digit_q - 3'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) digit_q <= '0;
    else          digit_q <= digit_d;
  end

  assign digit_o = digit_q;
  assign cy_o    = up_i ? (digit_q == 3'd7) : (digit_q == 3'd0);

endmodule

// File: rtl/oct_stopwatch.sv
// Multi-digit octal up/down stopwatch: synchronizers, start/stop edge detect,
// run/stop FSM, tick prescaler and a chain of octal digit counters.
module oct_stopwatch
  import oct_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_stop_i,
  input  logic                    clear_i,
  input  logic                    up_i,
  output logic [OCT_W*DIGITS-1:0] digits_o,
  output logic                    running_o,
  output logic                    wrap_o
);

  localparam int            PW        = clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [2:0]    ss_sync_q, ss_sync_d;
  logic [1:0]    clr_sync_q, clr_sync_d;
  logic [1:0]    up_sync_q, up_sync_d;
  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, running_d;
  logic          wrap_q, wrap_d;

  logic              ss_p, clear_s, up_s, tick, carry_all;
  logic [DIGITS-1:0] en, cy;

  always_comb begin
    ss_sync_d  = {ss_sync_q[1:0], start_stop_i};
    clr_sync_d = {clr_sync_q[0], clear_i};
    up_sync_d  = {up_sync_q[0], up_i};

    ss_p    = ss_sync_q[1] & ~ss_sync_q[2];
    clear_s = clr_sync_q[1];
    up_s    = up_sync_q[1];

    tick = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

    presc_d = presc_q;
    if (clear_s || tick)       presc_d = '0;
    else if (state_q == ST_RUN) presc_d = presc_q + 1'b1;

    // A toggle landing on a tick cycle still lets that tick through first.
    state_d = state_q;
    if (ss_p) state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
    running_d = (state_d == ST_RUN);

    // Ripple enable: digit k steps only when every lower digit rolls over.
    carry_all = tick;
    for (int k = 0; k < DIGITS; k++) begin
      en[k]     = carry_all;
      carry_all = carry_all & cy[k];
    end
    wrap_d = carry_all & ~clear_s;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ss_sync_q  <= '0;
      clr_sync_q <= '0;
      up_sync_q  <= '0;
      state_q    <= ST_STOP;
      presc_q    <= '0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      ss_sync_q  <= ss_sync_d;
      clr_sync_q <= clr_sync_d;
      up_sync_q  <= up_sync_d;
      state_q    <= state_d;
      presc_q    <= presc_d;
      running_q  <= running_d;
      wrap_q     <= wrap_d;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    oct_digit_cnt u_dig (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (en[g]),
      .up_i    (up_s),
      .clr_i   (clear_s),
      .digit_o (digits_o[g*OCT_W +: OCT_W]),
      .cy_o    (cy[g])
    );
  end

  assign running_o = running_q;
  assign wrap_o    = wrap_q;

endmodule
